// File: rtl/cvxif_result_requant_stage.sv
// cvxif_result_requant_stage: requantizes coprocessor results and buffers them for the x_result handshake.
// Optional macro CVXIF_REQUANT_RELU_EN adds in_relu_i. Revision 1.0.
`default_nettype none

module cvxif_result_requant_stage #(
  parameter int DEPTH    = 4,
  parameter int ID_WIDTH = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [ID_WIDTH-1:0]        in_id_i,
  input  logic [4:0]                 in_rd_i,
  input  logic                       in_we_i,
  input  logic [31:0]                in_data_i,
  input  logic                       in_requant_i,
  input  logic [4:0]                 in_shift_i,
`ifdef CVXIF_REQUANT_RELU_EN
  input  logic                       in_relu_i,
`endif
  output logic                       x_result_valid_o,
  input  logic                       x_result_ready_i,
  output logic [ID_WIDTH-1:0]        x_result_id_o,
  output logic [4:0]                 x_result_rd_o,
  output logic                       x_result_we_o,
  output logic [31:0]                x_result_data_o,
  output logic [$clog2(DEPTH+1)-1:0] usage_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int UW = $clog2(DEPTH+1);

  logic relu_in;
`ifdef CVXIF_REQUANT_RELU_EN
  assign relu_in = in_relu_i;
`else
  assign relu_in = 1'b0;
`endif

  // S1 register
  logic                s1_valid;
  logic [ID_WIDTH-1:0] s1_id;
  logic [4:0]          s1_rd;
  logic                s1_we;
  logic signed [32:0]  s1_r;
  logic                s1_requant;
  logic                s1_relu;

  // FIFO storage
  logic [ID_WIDTH-1:0] mem_id   [DEPTH];
  logic [4:0]          mem_rd   [DEPTH];
  logic                mem_we   [DEPTH];
  logic [31:0]         mem_data [DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [UW-1:0]       fifo_count;

  logic               accept, push, pop;
  logic [32:0]        rnd, sum;
  logic signed [32:0] shifted;
  logic signed [32:0] lo;
  logic [31:0]        clamped;

  assign usage_o          = fifo_count + UW'(s1_valid);
  assign in_ready_o       = (usage_o < UW'(DEPTH));
  assign accept           = in_valid_i & in_ready_o;
  assign x_result_valid_o = (fifo_count != '0);
  assign push             = s1_valid;
  assign pop              = x_result_valid_o & x_result_ready_i;

  // Rounding add is done in 33 bits so 0x7FFFFFFF plus half an LSB cannot wrap.
  always_comb begin
    rnd = '0;
    if (in_shift_i != 5'd0) rnd[in_shift_i - 5'd1] = 1'b1;
    sum = {in_data_i[31], in_data_i} + rnd;
    shifted = $signed(sum) >>> in_shift_i;
  end

  always_comb begin
    lo      = s1_relu ? 33'sd0 : -33'sd128;
    clamped = s1_r[31:0];
    if (s1_requant) begin
      if (s1_r > 33'sd127)  clamped = 32'd127;
      else if (s1_r < lo)   clamped = lo[31:0];
    end
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      s1_valid   <= 1'b0;
      s1_id      <= '0;
      s1_rd      <= '0;
      s1_we      <= 1'b0;
      s1_r       <= '0;
      s1_requant <= 1'b0;
      s1_relu    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_id      <= in_id_i;
        s1_rd      <= in_rd_i;
        s1_we      <= in_we_i;
        s1_r       <= in_requant_i ? shifted : $signed({in_data_i[31], in_data_i});
        s1_requant <= in_requant_i;
        s1_relu    <= in_requant_i & relu_in;
      end
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_id[wr_ptr]   <= s1_id;
      mem_rd[wr_ptr]   <= s1_rd;
      mem_we[wr_ptr]   <= s1_we;
      mem_data[wr_ptr] <= clamped;
    end
  end

  assign x_result_id_o   = x_result_valid_o ? mem_id[rd_ptr]   : '0;
  assign x_result_rd_o   = x_result_valid_o ? mem_rd[rd_ptr]   : '0;
  assign x_result_we_o   = x_result_valid_o ? mem_we[rd_ptr]   : 1'b0;
  assign x_result_data_o = x_result_valid_o ? mem_data[rd_ptr] : '0;

endmodule

`default_nettype wire

// File: tb/tb_cvxif_result_requant_stage.sv
// Directed self-checking bench for cvxif_result_requant_stage (DEPTH=4, ID_WIDTH=3).
`default_nettype none

module tb_cvxif_result_requant_stage;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [2:0]  in_id_i;
  logic [4:0]  in_rd_i;
  logic        in_we_i;
  logic [31:0] in_data_i;
  logic        in_requant_i;
  logic [4:0]  in_shift_i;
  logic        in_relu_i;
  logic        x_result_valid_o;
  logic        x_result_ready_i;
  logic [2:0]  x_result_id_o;
  logic [4:0]  x_result_rd_o;
  logic        x_result_we_o;
  logic [31:0] x_result_data_o;
  logic [2:0]  usage_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  cvxif_result_requant_stage #(.DEPTH(4), .ID_WIDTH(3)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .flush_i          (flush_i),
    .in_valid_i       (in_valid_i),
    .in_ready_o       (in_ready_o),
    .in_id_i          (in_id_i),
    .in_rd_i          (in_rd_i),
    .in_we_i          (in_we_i),
    .in_data_i        (in_data_i),
    .in_requant_i     (in_requant_i),
    .in_shift_i       (in_shift_i),
`ifdef CVXIF_REQUANT_RELU_EN
    .in_relu_i        (in_relu_i),
`endif
    .x_result_valid_o (x_result_valid_o),
    .x_result_ready_i (x_result_ready_i),
    .x_result_id_o    (x_result_id_o),
    .x_result_rd_o    (x_result_rd_o),
    .x_result_we_o    (x_result_we_o),
    .x_result_data_o  (x_result_data_o),
    .usage_o          (usage_o)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Presents one result for one edge, then waits until it sits at the FIFO head.
  task automatic send_one(input logic [31:0] d, input logic [4:0] sh,
                          input logic rq, input logic rl);
    in_valid_i = 1'b1; in_id_i = 3'd1; in_rd_i = 5'd3; in_we_i = 1'b1;
    in_data_i = d; in_shift_i = sh; in_requant_i = rq; in_relu_i = rl;
    tick();
    in_valid_i = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; in_id_i = '0; in_rd_i = '0;
    in_we_i = 1'b0; in_data_i = '0; in_requant_i = 1'b0; in_shift_i = '0;
    in_relu_i = 1'b0; x_result_ready_i = 1'b0;
    tick(); tick();
    rst_ni = 1'b1;
    checks++;
    if (x_result_valid_o !== 1'b0 || usage_o !== 3'd0 || in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: valid=%b usage=%0d ready=%b, required 0/0/1",
               x_result_valid_o, usage_o, in_ready_o);
    end
    checks++;
    if (x_result_data_o !== 32'd0 || x_result_id_o !== 3'd0 || x_result_rd_o !== 5'd0 ||
        x_result_we_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_fields: data=%h id=%0d rd=%0d we=%b, required zeros",
               x_result_data_o, x_result_id_o, x_result_rd_o, x_result_we_o);
    end
  endtask

  task automatic test_passthrough();
    x_result_ready_i = 1'b1;
    in_valid_i = 1'b1; in_id_i = 3'd2; in_rd_i = 5'd5; in_we_i = 1'b1;
    in_data_i = 32'h12345678; in_requant_i = 1'b0; in_shift_i = 5'd7;
    tick();
    in_valid_i = 1'b0;
    checks++;
    if (x_result_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL pass_no_fallthrough: valid=%b, required 0", x_result_valid_o);
    end
    tick();
    checks++;
    if (x_result_valid_o !== 1'b1 || x_result_data_o !== 32'h12345678 ||
        x_result_id_o !== 3'd2 || x_result_rd_o !== 5'd5 || x_result_we_o !== 1'b1) begin
      errors++;
      $display("FAIL pass_out: valid=%b data=%h id=%0d rd=%0d we=%b, required 1/12345678/2/5/1",
               x_result_valid_o, x_result_data_o, x_result_id_o, x_result_rd_o, x_result_we_o);
    end
    tick();
    checks++;
    if (x_result_valid_o !== 1'b0 || usage_o !== 3'd0) begin
      errors++;
      $display("FAIL pass_drain: valid=%b usage=%0d, required 0/0", x_result_valid_o, usage_o);
    end
  endtask

  task automatic test_requant();
    logic [31:0] d [7]   = '{32'd300, -32'sd5, 32'd7, 32'd100000, -32'sd100000,
                             32'h7FFFFFFF, -32'sd50};
    logic [4:0]  s [7]   = '{5'd2, 5'd1, 5'd0, 5'd4, 5'd4, 5'd31, 5'd0};
    logic [31:0] exp [7] = '{32'h0000004B, 32'hFFFFFFFE, 32'd7, 32'h0000007F,
                             32'hFFFFFF80, 32'd1, 32'hFFFFFFCE};
    x_result_ready_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send_one(d[i], s[i], 1'b1, 1'b0);
      checks++;
      if (x_result_valid_o !== 1'b1 || x_result_data_o !== exp[i]) begin
        errors++;
        $display("FAIL requant_%0d: valid=%b data=%h, required 1/%h",
                 i, x_result_valid_o, x_result_data_o, exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_relu();
`ifdef CVXIF_REQUANT_RELU_EN
    logic [31:0] d [3]   = '{-32'sd50, -32'sd50, 32'd500};
    logic        r [3]   = '{1'b1, 1'b0, 1'b1};
    logic [31:0] exp [3] = '{32'd0, 32'hFFFFFFCE, 32'd127};
    x_result_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_one(d[i], 5'd0, 1'b1, r[i]);
      checks++;
      if (x_result_data_o !== exp[i]) begin
        errors++;
        $display("FAIL relu_%0d: data=%h, required %h", i, x_result_data_o, exp[i]);
      end
      tick();
    end
    // ReLU has no effect on passthrough data
    send_one(-32'sd50, 5'd0, 1'b0, 1'b1);
    checks++;
    if (x_result_data_o !== 32'hFFFFFFCE) begin
      errors++;
      $display("FAIL relu_pass: data=%h, required ffffffce", x_result_data_o);
    end
    tick();
`endif
  endtask

  task automatic test_backpressure();
    int accepted = 0;
    x_result_ready_i = 1'b0;
    in_requant_i = 1'b0; in_rd_i = 5'd1; in_we_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid_i = 1'b1; in_id_i = 3'(i); in_data_i = 32'(i);
      if (in_ready_o) accepted++;
      tick();
    end
    in_valid_i = 1'b0;
    checks++;
    if (accepted != 4 || in_ready_o !== 1'b0 || usage_o !== 3'd4) begin
      errors++;
      $display("FAIL bp_fill: accepted=%0d ready=%b usage=%0d, required 4/0/4",
               accepted, in_ready_o, usage_o);
    end
    x_result_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (x_result_valid_o !== 1'b1 || x_result_id_o !== 3'(i) || x_result_data_o !== 32'(i)) begin
        errors++;
        $display("FAIL bp_order_%0d: valid=%b id=%0d data=%h, required 1/%0d/%h",
                 i, x_result_valid_o, x_result_id_o, x_result_data_o, i, i);
      end
      tick();
      if (i == 0) begin
        checks++;
        if (in_ready_o !== 1'b1 || usage_o !== 3'd3) begin
          errors++;
          $display("FAIL bp_ready_reassert: ready=%b usage=%0d, required 1/3", in_ready_o, usage_o);
        end
      end
    end
    checks++;
    if (x_result_valid_o !== 1'b0 || usage_o !== 3'd0) begin
      errors++;
      $display("FAIL bp_empty: valid=%b usage=%0d, required 0/0", x_result_valid_o, usage_o);
    end
  endtask

  task automatic test_back_to_back();
    x_result_ready_i = 1'b1;
    in_requant_i = 1'b0;
    for (int j = 0; j < 8; j++) begin
      in_valid_i = (j < 6); in_id_i = 3'(j); in_data_i = 32'(j) * 32'h11;
      checks++;
      if (in_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready_%0d: ready=%b, required 1", j, in_ready_o);
      end
      tick();
      if (j >= 1 && j <= 6) begin
        checks++;
        if (x_result_valid_o !== 1'b1 || x_result_id_o !== 3'(j-1) ||
            x_result_data_o !== 32'(j-1) * 32'h11) begin
          errors++;
          $display("FAIL b2b_out_%0d: valid=%b id=%0d data=%h, required 1/%0d/%h",
                   j, x_result_valid_o, x_result_id_o, x_result_data_o, j-1, (j-1)*17);
        end
      end
    end
    in_valid_i = 1'b0;
  endtask

  task automatic test_flush();
    x_result_ready_i = 1'b0;
    in_requant_i = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      in_valid_i = 1'b1; in_id_i = 3'(i); in_data_i = 32'(i);
      tick();
    end
    flush_i = 1'b1; in_id_i = 3'd7; in_data_i = 32'hDEAD;
    tick();
    flush_i = 1'b0; in_valid_i = 1'b0;
    checks++;
    if (x_result_valid_o !== 1'b0 || usage_o !== 3'd0) begin
      errors++;
      $display("FAIL flush_clear: valid=%b usage=%0d, required 0/0", x_result_valid_o, usage_o);
    end
    tick(); tick();
    checks++;
    if (x_result_valid_o !== 1'b0 || usage_o !== 3'd0) begin
      errors++;
      $display("FAIL flush_dropped: valid=%b usage=%0d, required 0/0", x_result_valid_o, usage_o);
    end
    x_result_ready_i = 1'b1;
    in_valid_i = 1'b1; in_id_i = 3'd4; in_data_i = 32'h44;
    tick();
    in_valid_i = 1'b0;
    tick();
    checks++;
    if (x_result_valid_o !== 1'b1 || x_result_id_o !== 3'd4 || x_result_data_o !== 32'h44) begin
      errors++;
      $display("FAIL flush_after: valid=%b id=%0d data=%h, required 1/4/44",
               x_result_valid_o, x_result_id_o, x_result_data_o);
    end
    tick();
  endtask

  task automatic test_reset_midop();
    x_result_ready_i = 1'b0;
    in_valid_i = 1'b1; in_id_i = 3'd5;
    tick(); tick();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1; in_valid_i = 1'b0;
    checks++;
    if (x_result_valid_o !== 1'b0 || usage_o !== 3'd0 || in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_midop: valid=%b usage=%0d ready=%b, required 0/0/1",
               x_result_valid_o, usage_o, in_ready_o);
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_requant();
    test_relu();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
